// File: rtl/adc_cap_pkg.sv
// Shared types and helpers for the decimating ADC capture front end.
// Helpers work on 32-bit containers; callers cast the result to their own width (all widths <= 32).
package adc_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAKE = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Increment that sticks at the all-ones value of a wl-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned wl);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - wl);
    return (val >= max_v) ? max_v : val + 32'd1;
  endfunction

  // Reduce an in_wl-bit offset-binary sample to out_wl bits; OTR samples rail to the side of the MSB.
  function automatic logic [31:0] fmt_sample(input logic [31:0] smp, input logic otr,
                                             input int unsigned in_wl, input int unsigned out_wl,
                                             input logic round_en);
    logic [31:0] max_o;
    logic [31:0] res;
    int unsigned sh;
    sh    = in_wl - out_wl;
    max_o = 32'hFFFF_FFFF >> (32 - out_wl);
    if (otr) begin
      res = smp[in_wl-1] ? max_o : 32'd0;
    end else if (round_en && (sh > 0)) begin
      res = (smp >> sh) + ((smp >> (sh - 1)) & 32'd1);
      if (res > max_o) res = max_o;
    end else begin
      res = smp >> sh;
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_cap_fifo.sv
// Synchronous FIFO with extra-bit pointers; a write into a full FIFO is accepted when a read
// happens on the same edge.
module adc_cap_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WL    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic [WL-1:0] wr_data,
  input  logic          rd_en,
  output logic [WL-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [WL-1:0] mem_q [DEPTH];
  logic          do_rd, do_wr;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd_en && !empty;
    do_wr    = wr_req && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_rd) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/adc_capture_dec.sv
// ADC capture front end: standby/wake sequencing, decimation, formatting, output FIFO, counters.
// Define ADC_CAP_ROUND_EN to round non-OTR samples half-up instead of truncating.
module adc_capture_dec
  import adc_cap_pkg::*;
#(
  parameter int unsigned IN_WL      = 10,
  parameter int unsigned OUT_WL     = 8,
  parameter int unsigned DEC_WL     = 8,
  parameter int unsigned WAKE_CYC   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WL     = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [DEC_WL-1:0] DEC_N,
  input  logic [IN_WL-1:0]  DAT_ADC,
  input  logic              OTR_ADC,
  output logic              STBY_ADC,
  output logic [OUT_WL-1:0] DOUT,
  output logic              DVALID,
  input  logic              DREADY,
  output logic              OTR_STICKY,
  input  logic              OTR_CLR,
  output logic [CNT_WL-1:0] OTR_CNT,
  output logic [CNT_WL-1:0] DROP_CNT
);

  localparam int unsigned WAKE_WL = $clog2(WAKE_CYC + 1);
`ifdef ADC_CAP_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  state_e               state_q, state_d;
  logic                 stby_q, stby_d;
  logic [WAKE_WL-1:0]   wake_cnt_q, wake_cnt_d;
  logic [DEC_WL-1:0]    dec_lat_q, dec_lat_d;
  logic [DEC_WL-1:0]    dec_cnt_q, dec_cnt_d;
  logic [IN_WL-1:0]     s1_dat_q, s1_dat_d;
  logic                 s1_otr_q, s1_otr_d;
  logic                 otr_sticky_q, otr_sticky_d;
  logic [CNT_WL-1:0]    otr_cnt_q, otr_cnt_d;
  logic [CNT_WL-1:0]    drop_cnt_q, drop_cnt_d;
  logic                 sel;
  logic                 fifo_rd, fifo_full, fifo_empty;
  logic [OUT_WL-1:0]    fmt_dat;

  always_comb begin
    state_d    = state_q;
    stby_d     = stby_q;
    wake_cnt_d = wake_cnt_q;
    dec_lat_d  = dec_lat_q;
    dec_cnt_d  = dec_cnt_q;
    sel        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dec_lat_d  = DEC_N;
        wake_cnt_d = '0;
        dec_cnt_d  = '0;
        if (EN) begin
          state_d = ST_WAKE;
          stby_d  = 1'b0;
        end
      end
      ST_WAKE: begin
        dec_lat_d = DEC_N;
        if (!EN) begin
          state_d    = ST_IDLE;
          stby_d     = 1'b1;
          wake_cnt_d = '0;
        end else if (wake_cnt_q == WAKE_WL'(WAKE_CYC - 1)) begin
          state_d    = ST_RUN;
          wake_cnt_d = '0;
          dec_cnt_d  = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_WL'(1);
        end
      end
      ST_RUN: begin
        // A sample already in the input stage is still taken on the edge that leaves RUN.
        sel       = (dec_cnt_q == '0);
        dec_cnt_d = (dec_cnt_q == dec_lat_q) ? '0 : dec_cnt_q + DEC_WL'(1);
        if (!EN) begin
          state_d = ST_IDLE;
          stby_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stby_d  = 1'b1;
      end
    endcase
  end

  always_comb begin
    s1_dat_d     = DAT_ADC;
    s1_otr_d     = OTR_ADC;
    fmt_dat      = OUT_WL'(fmt_sample(32'(s1_dat_q), s1_otr_q, IN_WL, OUT_WL, ROUND_EN));
    fifo_rd      = !fifo_empty && DREADY;
    otr_sticky_d = otr_sticky_q;
    otr_cnt_d    = otr_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (sel && s1_otr_q) begin
      otr_sticky_d = 1'b1;
      otr_cnt_d    = CNT_WL'(sat_inc(32'(otr_cnt_q), CNT_WL));
    end
    if (OTR_CLR) begin
      otr_sticky_d = 1'b0;
      otr_cnt_d    = '0;
    end
    if (sel && fifo_full && !fifo_rd) drop_cnt_d = CNT_WL'(sat_inc(32'(drop_cnt_q), CNT_WL));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      stby_q       <= 1'b1;
      wake_cnt_q   <= '0;
      dec_lat_q    <= '0;
      dec_cnt_q    <= '0;
      s1_dat_q     <= '0;
      s1_otr_q     <= 1'b0;
      otr_sticky_q <= 1'b0;
      otr_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      stby_q       <= stby_d;
      wake_cnt_q   <= wake_cnt_d;
      dec_lat_q    <= dec_lat_d;
      dec_cnt_q    <= dec_cnt_d;
      s1_dat_q     <= s1_dat_d;
      s1_otr_q     <= s1_otr_d;
      otr_sticky_q <= otr_sticky_d;
      otr_cnt_q    <= otr_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  adc_cap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WL    (OUT_WL)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_req  (sel),
    .wr_data (fmt_dat),
    .rd_en   (fifo_rd),
    .rd_data (DOUT),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign STBY_ADC   = stby_q;
  assign DVALID     = !fifo_empty;
  assign OTR_STICKY = otr_sticky_q;
  assign OTR_CNT    = otr_cnt_q;
  assign DROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_adc_capture_dec.sv
// Directed and randomized bench for adc_capture_dec against a transaction-level reference model.
module tb_adc_capture_dec;

  localparam int IN_WL      = 10;
  localparam int OUT_WL     = 8;
  localparam int DEC_WL     = 8;
  localparam int WAKE_CYC   = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_WL     = 16;
  localparam int CNT_MAX    = 65535;

  logic              clk = 1'b0;
  logic              rst_n, en, otr, dready, clr;
  logic [DEC_WL-1:0] dec_n;
  logic [IN_WL-1:0]  dat;
  logic              stby, dvalid, sticky;
  logic [OUT_WL-1:0] dout;
  logic [CNT_WL-1:0] otr_cnt, drop_cnt;

  adc_capture_dec #(
    .IN_WL(IN_WL), .OUT_WL(OUT_WL), .DEC_WL(DEC_WL), .WAKE_CYC(WAKE_CYC),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_WL(CNT_WL)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DEC_N(dec_n), .DAT_ADC(dat), .OTR_ADC(otr),
    .STBY_ADC(stby), .DOUT(dout), .DVALID(dvalid), .DREADY(dready),
    .OTR_STICKY(sticky), .OTR_CLR(clr), .OTR_CNT(otr_cnt), .DROP_CNT(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: age = edges since EN was first seen high (-1 while in standby).
  int age, m_dec, m_s1, m_otr_cnt, m_drop;
  bit m_s1_otr, m_sticky;
  int q[$];
  int got[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int pre, v;
    bit sel, rd;
    if (!rst_n) begin
      age = -1; m_dec = 0; m_s1 = 0; m_s1_otr = 0;
      q.delete(); m_otr_cnt = 0; m_drop = 0; m_sticky = 0;
      return;
    end
    pre = age;
    v   = 0;
    sel = (pre >= WAKE_CYC) && (((pre - WAKE_CYC) % (m_dec + 1)) == 0);
    rd  = (q.size() > 0) && dready;
    if (pre < WAKE_CYC) m_dec = int'(dec_n);
    if (sel) begin
      if (m_s1_otr) begin
        v = (m_s1 >= 512) ? 255 : 0;
        m_sticky = 1;
        if (m_otr_cnt < CNT_MAX) m_otr_cnt++;
      end else begin
        v = m_s1 / 4;
      end
    end
    if (clr) begin
      m_otr_cnt = 0;
      m_sticky  = 0;
    end
    if (rd) void'(q.pop_front());
    if (sel) begin
      if (q.size() < FIFO_DEPTH) q.push_back(v);
      else if (m_drop < CNT_MAX) m_drop++;
    end
    if (pre < 0) age = en ? 0 : -1;
    else         age = en ? pre + 1 : -1;
    m_s1     = int'(dat);
    m_s1_otr = otr;
  endtask

  task automatic compare_all();
    check("stby",     32'(stby),     32'(age < 0));
    check("dvalid",   32'(dvalid),   32'(q.size() > 0));
    check("dout",     32'(dout),     32'((q.size() > 0) ? q[0] : 0));
    check("sticky",   32'(sticky),   32'(m_sticky));
    check("otr_cnt",  32'(otr_cnt),  32'(m_otr_cnt));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // One clock: log the transfer about to happen, advance DUT and model, then compare.
  task automatic step();
    if (rst_n && dvalid && dready) got.push_back(int'(dout));
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; otr = 1'b0; dready = 1'b0; clr = 1'b0; dec_n = '0; dat = '0;
    age = -1; m_dec = 0; m_s1 = 0; m_s1_otr = 0; m_otr_cnt = 0; m_drop = 0; m_sticky = 0;

    // Reset and standby
    step();
    step();
    check("rst_stby",    32'(stby),     32'd1);
    check("rst_dvalid",  32'(dvalid),   32'd0);
    check("rst_otr_cnt", 32'(otr_cnt),  32'd0);
    check("rst_drop",    32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Wake latency and decimation by 4 on a ramp
    dec_n = 8'd3; dready = 1'b1; en = 1'b1;
    got.delete();
    n = 0;
    do begin
      dat = (n >= 16) ? 10'(4 * (n - 16)) : '0;
      step();
      n++;
    end while (!dvalid && n < 40);
    check("wake_latency", 32'(n), 32'd18);
    for (int i = 0; i < 14; i++) begin
      dat = 10'(4 * (n - 16));
      step();
      n++;
    end
    check("dec_count", 32'(got.size() >= 3), 32'd1);
    check("dec_s0", 32'(got[0]), 32'h00);
    check("dec_s1", 32'(got[1]), 32'h04);
    check("dec_s2", 32'(got[2]), 32'h08);

    // OTR saturation and clear
    en = 1'b0; dat = '0;
    step();
    step();
    dec_n = '0; en = 1'b1;
    repeat (24) step();
    dat = 10'h3F0; otr = 1'b1;
    step();
    dat = 10'h010;
    step();
    check("otr_hi_sat", 32'(dout), 32'hFF);
    dat = '0; otr = 1'b0;
    step();
    check("otr_lo_sat", 32'(dout),    32'h00);
    check("otr_cnt2",   32'(otr_cnt), 32'd2);
    check("otr_sticky", 32'(sticky),  32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("otr_clr_cnt",    32'(otr_cnt), 32'd0);
    check("otr_clr_sticky", 32'(sticky),  32'd0);

    // Backpressure: one entry queued, ten stalled edges -> three more stored, seven dropped
    dready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      dat = 10'(256 + 8 * j);
      step();
      check("hold_dout",   32'(dout),   32'h00);
      check("hold_dvalid", 32'(dvalid), 32'd1);
    end
    check("drop_7", 32'(drop_cnt), 32'd7);

    // Full FIFO drained while writing every cycle: no further drops
    got.delete();
    dready = 1'b1;
    repeat (8) step();
    check("drain_count", 32'(got.size()), 32'd8);
    check("drain_0", 32'(got[0]), 32'h00);
    check("drain_1", 32'(got[1]), 32'h00);
    check("drain_2", 32'(got[2]), 32'h40);
    check("drain_3", 32'(got[3]), 32'h42);
    check("full_rd_drop", 32'(drop_cnt), 32'd7);
    check("full_rd_dvalid", 32'(dvalid), 32'd1);

    // Leaving RUN keeps the queued samples drainable
    en = 1'b0;
    step();
    check("en_off_stby", 32'(stby), 32'd1);
    got.delete();
    repeat (8) step();
    check("en_off_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("en_off_data", 32'(got[i]), 32'h52);
    check("en_off_empty", 32'(dvalid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      en     = ($urandom_range(0, 79) != 0);
      dec_n  = 8'($urandom_range(0, 3));
      dat    = 10'($urandom);
      otr    = ($urandom_range(0, 7) == 0);
      dready = ($urandom_range(0, 3) != 0);
      clr    = ($urandom_range(0, 40) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
